// File: rtl/div_pkg.sv
// Shared types and defaults for the divider scheduler and div_ctrl users.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_NREQ  = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } sched_st_t;

endpackage

// File: rtl/div_rr_arb.sv
// Combinational round-robin search starting at ptr_i; the pointer itself lives in the parent.
module div_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // First requester at or after ptr_i, wrapping modulo NREQ.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
    if (en_i && any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among NREQ requesters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | div_go low; grant when a request is pending and the slot is free
//   S_ISSUE   | div_go high; wait for div_fin, then capture the response
//   S_RELEASE | div_go low; wait for the divider to drop div_fin
module div_sched
  import div_pkg::*;
#(
  parameter int NREQ  = DIV_NREQ,
  parameter int WIDTH = DIV_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  div_go,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_fin,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_r,
  input  logic                  div_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           stat_ops
);

  sched_st_t        state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   pend_id_q, pend_id_d;
  logic [WIDTH-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d, rsp_r_q, rsp_r_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      stat_ops_q, stat_ops_d;

  logic             grant_en;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Grant only from idle with a free (or freeing) response slot; never while in reset.
  assign grant_en = (state_q == S_IDLE) && !rst && (!rsp_valid_q || rsp_ready);

  div_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (grant_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state, operand latch, response capture and pointer update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_id_d   = pend_id_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    rsp_r_d     = rsp_r_q;
    rsp_err_d   = rsp_err_q;
    stat_ops_d  = stat_ops_q;
    case (state_q)
      S_IDLE: begin
        if (grant_en && gnt_any) begin
          div_a_d   = sel_a;
          div_b_d   = sel_b;
          pend_id_d = gnt_idx;
          ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (div_fin) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = pend_id_q;
          rsp_q_d     = div_q;
          rsp_r_d     = div_r;
          rsp_err_d   = div_err;
          stat_ops_d  = stat_ops_q + 16'd1;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!div_fin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      pend_id_q   <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
      rsp_err_q   <= 1'b0;
      stat_ops_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_id_q   <= pend_id_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
      rsp_r_q     <= rsp_r_d;
      rsp_err_q   <= rsp_err_d;
      stat_ops_q  <= stat_ops_d;
    end
  end

  // div_go decodes the registered state, so it cannot glitch.
  assign req_ready = gnt;
  assign div_go    = (state_q == S_ISSUE);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign stat_ops  = stat_ops_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: behavioral divider plus a grant-time scoreboard of expected responses.
module tb_div_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int LAT   = 3;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             err;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  div_go;
  logic [WIDTH-1:0]      div_a, div_b;
  logic                  div_fin = 1'b0;
  logic [WIDTH-1:0]      div_q = '0;
  logic [WIDTH-1:0]      div_r = '0;
  logic                  div_err = 1'b0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_q, rsp_r;
  logic                  rsp_err;
  logic                  busy;
  logic [15:0]           stat_ops;

  int tests = 0;
  int fails = 0;
  int ops_done = 0;
  int go_rises = 0;
  logic prev_go = 1'b0;
  logic [NREQ-1:0] last_g = '0;
  logic last_acc = 1'b0;
  exp_t sb[$];
  int gnt_log[$];
  int dcnt = 0;

  always #5 clk = ~clk;

  div_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .div_go    (div_go),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_fin   (div_fin),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_err   (div_err),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .stat_ops  (stat_ops)
  );

  // Behavioral divider: fin after LAT cycles of go, held while go stays high, dropped after go falls.
  always @(posedge clk) begin
    if (rst) begin
      div_fin <= 1'b0;
      dcnt    <= 0;
    end else if (div_go && !div_fin) begin
      if (dcnt == LAT - 1) begin
        div_fin <= 1'b1;
        div_err <= (div_b == 8'd0);
        div_q   <= (div_b == 8'd0) ? 8'hFF : div_a / div_b;
        div_r   <= (div_b == 8'd0) ? div_a : div_a % div_b;
        dcnt    <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else if (!div_go) begin
      div_fin <= 1'b0;
      dcnt    <= 0;
    end
  end

  // One clock: observe at negedge (grants push expectations, accepts pop and compare), drive after posedge.
  task automatic tick();
    logic [NREQ-1:0] g;
    logic [WIDTH-1:0] a, b;
    int idx;
    exp_t e;
    idx = 0;
    @(negedge clk);
    g = req_ready;
    last_g = g;
    last_acc = rsp_valid && rsp_ready;
    if (div_go && !prev_go) go_rises++;
    prev_go = div_go;
    if (g != '0) begin
      tests++;
      if (!$onehot(g)) begin
        fails++;
        $display("FAIL grant_onehot: req_ready=%b, required one-hot", g);
      end
      for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
      a = req_a[idx*WIDTH +: WIDTH];
      b = req_b[idx*WIDTH +: WIDTH];
      e.id  = idx[IDW-1:0];
      e.err = (b == 8'd0);
      e.q   = (b == 8'd0) ? 8'hFF : a / b;
      e.r   = (b == 8'd0) ? a : a % b;
      sb.push_back(e);
      gnt_log.push_back(idx);
    end
    if (last_acc) begin
      ops_done++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: id=%0d q=%0d r=%0d, required no response", rsp_id, rsp_q, rsp_r);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_q, rsp_r, rsp_err} !== e) begin
          fails++;
          $display("FAIL rsp_data: got id=%0d q=%0d r=%0d err=%0d, required id=%0d q=%0d r=%0d err=%0d",
                   rsp_id, rsp_q, rsp_r, rsp_err, e.id, e.q, e.r, e.err);
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_ops_until(input int target);
    int k;
    k = 0;
    while (ops_done < target && k < 400) begin
      tick();
      k++;
    end
    tests++;
    if (ops_done < target) begin
      fails++;
      $display("FAIL ops_timeout: completed=%0d, required %0d", ops_done, target);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    gnt_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
    end
    tests++;
    if ({div_go, div_a, div_b} !== 17'd0) begin
      fails++;
      $display("FAIL reset_div: go=%b a=%0d b=%0d, required all 0", div_go, div_a, div_b);
    end
    tests++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err} !== 20'd0) begin
      fails++;
      $display("FAIL reset_rsp: valid=%b id=%0d q=%0d r=%0d err=%b, required all 0",
               rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err);
    end
    tests++;
    if ({busy, stat_ops} !== 17'd0) begin
      fails++;
      $display("FAIL reset_status: busy=%b stat_ops=%0d, required 0", busy, stat_ops);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int k;
    set_req(2, 8'd100, 8'd7);
    k = 0;
    do begin
      tick();
      k++;
    end while (last_g == '0 && k < 10);
    tests++;
    if (last_g !== 4'b0100) begin
      fails++;
      $display("FAIL single_grant: req_ready=%b, required 0100", last_g);
    end
    tests++;
    if ({div_go, req_ready, div_a, div_b} !== {1'b1, 4'b0000, 8'd100, 8'd7}) begin
      fails++;
      $display("FAIL single_issue: go=%b req_ready=%b a=%0d b=%0d, required go=1 req_ready=0000 a=100 b=7",
               div_go, req_ready, div_a, div_b);
    end
    wait_ops_until(ops_done + 1);
    tests++;
    if (stat_ops !== 16'd1) begin
      fails++;
      $display("FAIL single_stat: stat_ops=%0d, required 1", stat_ops);
    end
    wait_idle();
  endtask

  task automatic test_div_zero();
    go_rises = 0;
    prev_go = div_go;
    set_req(0, 8'd55, 8'd0);
    wait_ops_until(ops_done + 1);
    wait_idle();
    repeat (3) tick();
    tests++;
    if (go_rises !== 1) begin
      fails++;
      $display("FAIL divzero_go_pulses: div_go rises=%0d, required 1", go_rises);
    end
    tests++;
    if (stat_ops !== 16'd2) begin
      fails++;
      $display("FAIL divzero_stat: stat_ops=%0d, required 2", stat_ops);
    end
  endtask

  task automatic test_all_four();
    int exp_order[5];
    int start;
    int k;
    logic reloaded;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    start = ops_done;
    reloaded = 1'b0;
    set_req(0, 8'd200, 8'd13);
    set_req(1, 8'd150, 8'd10);
    set_req(2, 8'd99,  8'd7);
    set_req(3, 8'd37,  8'd5);
    k = 0;
    while (gnt_log.size() < 5 && k < 200) begin
      tick();
      if (!reloaded && gnt_log.size() == 1) begin
        set_req(0, 8'd77, 8'd6);
        reloaded = 1'b1;
      end
      k++;
    end
    wait_ops_until(start + 5);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= gnt_log.size()) begin
        fails++;
        $display("FAIL rr_order[%0d]: no grant, required %0d", i, exp_order[i]);
      end else if (gnt_log[i] != exp_order[i]) begin
        fails++;
        $display("FAIL rr_order[%0d]: granted %0d, required %0d", i, gnt_log[i], exp_order[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_back_pressure();
    logic [IDW+2*WIDTH:0] snap;
    int k, bad_stable, bad_grant;
    rsp_ready = 1'b0;
    set_req(1, 8'd50, 8'd4);
    set_req(2, 8'd81, 8'd9);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
    end
    snap = {rsp_id, rsp_q, rsp_r, rsp_err};
    bad_stable = 0;
    bad_grant = 0;
    repeat (20) begin
      tick();
      if (!rsp_valid || {rsp_id, rsp_q, rsp_r, rsp_err} !== snap) bad_stable++;
      if (last_g != '0 || req_ready != '0) bad_grant++;
    end
    tests++;
    if (bad_stable != 0 || snap !== {2'd1, 8'd12, 8'd2, 1'b0}) begin
      fails++;
      $display("FAIL bp_hold: unstable cycles=%0d held=%h, required 0 and %h", bad_stable, snap,
               {2'd1, 8'd12, 8'd2, 1'b0});
    end
    tests++;
    if (bad_grant != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall: grant cycles=%0d busy=%b, required 0 and 0", bad_grant, busy);
    end
    rsp_ready = 1'b1;
    tick();
    tests++;
    if ({last_acc, last_g} !== {1'b1, 4'b0100}) begin
      fails++;
      $display("FAIL bp_release: accept=%b grant=%b, required accept=1 grant=0100", last_acc, last_g);
    end
    wait_ops_until(ops_done + 1);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int k;
    set_req(1, 8'd200, 8'd9);
    k = 0;
    while (!div_go && k < 20) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    tests++;
    if ({div_go, rsp_valid, busy, req_ready} !== 7'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: go=%b rsp_valid=%b busy=%b req_ready=%b, required all 0",
               div_go, rsp_valid, busy, req_ready);
    end
    tests++;
    if ({dut.ptr_q, stat_ops} !== 18'd0) begin
      fails++;
      $display("FAIL rstmid_regs: ptr=%0d stat_ops=%0d, required 0 and 0", dut.ptr_q, stat_ops);
    end
    set_req(2, 8'd9, 8'd3);
    wait_ops_until(ops_done + 1);
    tests++;
    if (stat_ops !== 16'd1) begin
      fails++;
      $display("FAIL rstmid_after: stat_ops=%0d, required 1", stat_ops);
    end
    wait_idle();
  endtask

  task automatic test_stat_wrap();
    force dut.stat_ops_q = 16'hFFFF;
    tick();
    release dut.stat_ops_q;
    tick();
    tests++;
    if (stat_ops !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preload: stat_ops=%h, required ffff", stat_ops);
    end
    set_req(0, 8'd10, 8'd3);
    wait_ops_until(ops_done + 1);
    tests++;
    if (stat_ops !== 16'h0000) begin
      fails++;
      $display("FAIL wrap: stat_ops=%h, required 0000", stat_ops);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_all_four();
    test_back_pressure();
    test_reset_mid();
    test_stat_wrap();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: %0d responses never seen, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_sched.md
# div_sched

Scheduler that shares one iterative divider unit (the `div_ctrl` controller plus its datapath) among `NREQ` requesters. Arbitration is round-robin. The scheduler latches the winner's operands and drives the divider's level-sensitive `go`/`fin` handshake. It returns quotient, remainder and error, tagged with the requester index, through a single-entry response register with backpressure.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; must be ≥2.
- `WIDTH`, default 8: dividend, divisor, quotient and remainder width.
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NREQ`: per-requester request, held until granted.
- `req_a`, in, `NREQ*WIDTH`: dividends, packed with requester i at bits `[i*WIDTH +: WIDTH]`.
- `req_b`, in, `NREQ*WIDTH`: divisors, packed the same way.
- `req_ready`, out, `NREQ`: one-hot grant pulse; the operands are sampled in that cycle.
- `div_go`, out, 1: level start to the divider.
- `div_a`, out, `WIDTH`: latched dividend.
- `div_b`, out, `WIDTH`: latched divisor.
- `div_fin`, in, 1: divider done level.
- `div_q`, in, `WIDTH`: divider quotient.
- `div_r`, in, `WIDTH`: divider remainder.
- `div_err`, in, 1: divide-by-zero flag.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, `IDW`: index of the originating requester.
- `rsp_q`, out, `WIDTH`: quotient.
- `rsp_r`, out, `WIDTH`: remainder.
- `rsp_err`, out, 1: divide-by-zero flag.
- `busy`, out, 1: high whenever the FSM is not in `S_IDLE`.
- `stat_ops`, out, 16: count of completed operations; wraps modulo 2^16.

## Operation
Divider protocol:
- `div_go` is a level signal.
- The divider raises `div_fin` when it finishes and holds it while `div_go` stays high.
- After `div_go` drops, the divider lowers `div_fin` and returns to idle.
- The scheduler never re-raises `div_go` until it has sampled `div_fin` low.

FSM states (in `div_pkg`):
- `S_IDLE`: `div_go`=0.
  - Grant is allowed only when some `req_valid` bit is set and the response slot is free, i.e. `!rsp_valid` or `(rsp_valid && rsp_ready)` in the same cycle.
  - On grant: pulse the winner's `req_ready` bit, latch the winner's `req_a`/`req_b` into `div_a`/`div_b`, latch its index as the pending id, go to `S_ISSUE`.
- `S_ISSUE`: `div_go`=1.
  - On `div_fin`=1: capture `div_q`, `div_r`, `div_err` and the pending id into the response registers; set `rsp_valid`; increment `stat_ops`; go to `S_RELEASE`.
- `S_RELEASE`: `div_go`=0.
  - When `div_fin` is sampled 0, go to `S_IDLE`.

Arbitration:
- Round-robin pointer `ptr`; reset value 0.
- Search order is `ptr`, `ptr+1`, … modulo `NREQ`.
- On a grant to index g, `ptr` ← (g+1) mod `NREQ`. With no grant, `ptr` is unchanged.

Response register:
- `rsp_valid` clears on `rsp_valid && rsp_ready`.
- Capture in `S_ISSUE` cannot collide with a held response, because a grant requires the slot to be free.
- `rsp_*` data holds stable while `rsp_valid && !rsp_ready`.

Widths and values:
- `div_q` and `div_r` are forwarded unmodified.
- On `div_err`=1, `rsp_err`=1 and q/r are whatever the divider reports; no special casing.

Reset values (every output and register):
- `req_ready`=0, `div_go`=0, `div_a`=0, `div_b`=0.
- `rsp_valid`=0, `rsp_id`=0, `rsp_q`=0, `rsp_r`=0, `rsp_err`=0.
- `busy`=0, `stat_ops`=0, `ptr`=0, state `S_IDLE`.

## Timing
Latency for a grant in cycle t:
- `div_go`=1 from t+1.
- If `div_fin` is first sampled high in cycle f: `rsp_valid`=1 and `div_go`=0 from f+1.
- `S_IDLE` is re-entered the cycle after `div_fin` is sampled low (f+3 with a divider that drops `fin` one cycle after `go` falls).
- Earliest next grant is in that `S_IDLE` cycle.

Boundary conditions:
- `req_valid` deasserted before grant: the request is dropped silently; requesters must hold `req_valid`.
- All requesters valid: grants rotate 0,1,2,3,0,… with no starvation.
- Response back-pressured: the scheduler stalls in `S_IDLE` with `req_ready`=0 until `rsp_ready`.
- Response accepted in the same `S_IDLE` cycle as a new grant: both happen in that cycle.
- Reset mid-operation: state and all registers return to reset values in the next cycle and any in-flight result is discarded. The divider shares `rst`.
- `stat_ops` at 16'hFFFF followed by a completion: wraps to 0.

## Structure
- `div_pkg` holds the `sched_st_t` enum (`S_IDLE`, `S_ISSUE`, `S_RELEASE`) and the default `WIDTH`/`NREQ` constants, shared with `div_ctrl` users.
- Sub-module `div_rr_arb` (params `NREQ`):
  - Inputs: `req` vector, `ptr`, grant-enable.
  - Outputs: one-hot `gnt` and the encoded index.
  - Combinational search; `ptr` is registered in `div_sched`.

## Test plan
- Single request, requester 2, a=100, b=7 → `req_ready`=4'b0100 for one cycle; response `rsp_id`=2, q=14, r=2, err=0; `stat_ops`=1.
- Divide by zero, requester 0, a=55, b=0 → `rsp_err`=1, `rsp_id`=0; FSM returns to `S_IDLE`; no `div_go` glitch.
- All four requesters valid continuously, distinct operands → grant order 0,1,2,3,0; each response's id and quotient match its operands.
- `rsp_ready` held 0 for 20 cycles after the first response → `rsp_*` stable; no further `req_ready`; on release the next grant occurs in the same cycle as acceptance.
- `rst` asserted while in `S_ISSUE` → next cycle `div_go`=0, `rsp_valid`=0, `ptr`=0, `busy`=0; a subsequent request completes correctly.
- Preload 65535 operations (force) then one more completion → `stat_ops` wraps to 0.
